// File: rtl/secuenciador_biquad_param.sv
// secuenciador_biquad_param: N-op / W-wait / C-channel MAC sequencer driving the biquad datapath selects and enables.
// Sticky overrun reporting is built only when SEQ_OVERRUN_EN is defined.
module secuenciador_biquad_param #(
  parameter int N_OPS = 5,
  parameter int WAIT_CYC = 4,
  parameter int N_CH = 1,
  localparam int OPW = $clog2(N_OPS + 1),
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             datolisto,
  input  logic             clr_overrun,
  output logic [OPW-1:0]   op_sel,
  output logic [N_OPS-1:0] en_op,
  output logic             en_suma,
  output logic             en_hist,
  output logic [CHW-1:0]   canal,
  output logic             resultadolisto,
  output logic             busy,
  output logic             overrun
);
  localparam int WW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [OPW-1:0] OP_LAST = OPW'(N_OPS);
  localparam logic [WW-1:0] W_LAST = WW'(WAIT_CYC);
  localparam logic [CHW-1:0] CH_LAST = CHW'(N_CH - 1);
  localparam logic [N_OPS-1:0] OP_ONE = N_OPS'(1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINAL, RESULT} state_t;
  state_t state;
  logic [OPW-1:0] op_cnt;
  logic [WW-1:0] w_cnt;
  logic [CHW-1:0] ch_cnt;
  logic last_op, fire;
  assign last_op = op_cnt == OP_LAST;
  // with no wait cycles the capture happens in the issue cycle itself
  assign fire = (state == ISSUE && WAIT_CYC == 0) || (state == WAIT && w_cnt == W_LAST);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      op_cnt <= '0;
      w_cnt <= '0;
      ch_cnt <= '0;
    end else
      case (state)
        IDLE:
          if (datolisto) begin
            state <= ISSUE;
            op_cnt <= OPW'(1);
            ch_cnt <= '0;
          end
        ISSUE:
          if (WAIT_CYC != 0) begin
            state <= WAIT;
            w_cnt <= WW'(1);
          end else if (last_op) state <= FINAL;
          else op_cnt <= op_cnt + 1'b1;
        WAIT:
          if (w_cnt != W_LAST) w_cnt <= w_cnt + 1'b1;
          else if (last_op) state <= FINAL;
          else begin
            op_cnt <= op_cnt + 1'b1;
            state <= ISSUE;
          end
        FINAL: state <= RESULT;
        RESULT:
          if (ch_cnt != CH_LAST) begin
            ch_cnt <= ch_cnt + 1'b1;
            op_cnt <= OPW'(1);
            state <= ISSUE;
          end else state <= IDLE;
        default: state <= IDLE;
      endcase
  assign op_sel = state == ISSUE ? op_cnt : '0;
  assign en_op = fire ? OP_ONE << (op_cnt - 1'b1) : '0;
  assign en_suma = state == FINAL;
  assign en_hist = state == RESULT;
  assign resultadolisto = state == RESULT && ch_cnt == CH_LAST;
  assign canal = state == IDLE ? '0 : ch_cnt;
  assign busy = state != IDLE;
`ifdef SEQ_OVERRUN_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun <= 1'b0;
    else if (datolisto && busy) overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
`else
  logic unused_clr;
  assign unused_clr = clr_overrun;
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_secuenciador_biquad_param.sv
// tb_secuenciador_biquad_param: table + timing-formula scoreboard for the defaults (5,4,1) and a (3,0,2) instance.
module tb_secuenciador_biquad_param;
`ifdef SEQ_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, da = 1'b0, db = 1'b0, clr = 1'b0;
  logic [2:0] op_a;
  logic [4:0] en_a;
  logic [0:0] ca_a;
  logic su_a, hi_a, rl_a, bz_a, ov_a;
  logic [1:0] op_b;
  logic [2:0] en_b;
  logic [0:0] ca_b;
  logic su_b, hi_b, rl_b, bz_b, ov_b;
  int ntests = 0, nfail = 0;
  typedef struct {string nm; int cyc; logic [31:0] w;} sb_t;
  typedef struct {int cyc; int op; int en; bit s; bit h; bit r; bit b;} vec_t;
  sb_t qa[$], qb[$];
  vec_t tbl[14];

  secuenciador_biquad_param dut_a (
    .clk(clk), .reset(reset), .datolisto(da), .clr_overrun(clr),
    .op_sel(op_a), .en_op(en_a), .en_suma(su_a), .en_hist(hi_a), .canal(ca_a),
    .resultadolisto(rl_a), .busy(bz_a), .overrun(ov_a));

  secuenciador_biquad_param #(.N_OPS(3), .WAIT_CYC(0), .N_CH(2)) dut_b (
    .clk(clk), .reset(reset), .datolisto(db), .clr_overrun(clr),
    .op_sel(op_b), .en_op(en_b), .en_suma(su_b), .en_hist(hi_b), .canal(ca_b),
    .resultadolisto(rl_b), .busy(bz_b), .overrun(ov_b));

  always #5 clk = ~clk;

  // word layout: op_sel[31:28] en_op[27:12] canal[11:9] suma hist res busy ovr [8:4]
  function automatic logic [31:0] pack(int op, int en, bit s, bit h, int ch, bit r, bit b, bit o);
    return {4'(op), 16'(en), 3'(ch), s, h, r, b, o, 4'b0};
  endfunction

  // expected outputs t cycles after the IDLE cycle that sampled datolisto, from the timing formulas
  function automatic logic [31:0] model(int n, int w, int c, int t, bit o);
    int l, r, ch, k, p;
    l = n * (w + 1) + 2;
    if (t < 1 || t > c * l) return pack(0, 0, 0, 0, 0, 0, 0, o);
    r = (t - 1) % l;
    ch = (t - 1) / l;
    if (r < n * (w + 1)) begin
      k = r / (w + 1) + 1;
      p = r % (w + 1);
      return pack(p == 0 ? k : 0, p == w ? 1 << (k - 1) : 0, 0, 0, ch, 0, 1, o);
    end
    return r == n * (w + 1) ? pack(0, 0, 1, 0, ch, 0, 1, o) : pack(0, 0, 0, 1, ch, ch == c - 1, 1, o);
  endfunction

  task automatic cmp(sb_t e, logic [31:0] act);
    ntests++;
    if (act !== e.w) begin
      nfail++;
      $display("FAIL %s cycle %0d: got %h expected %h", e.nm, e.cyc, act, e.w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (qa.size() > 0) cmp(qa.pop_front(), pack(int'(op_a), int'(en_a), su_a, hi_a, int'(ca_a), rl_a, bz_a, ov_a));
    if (qb.size() > 0) cmp(qb.pop_front(), pack(int'(op_b), int'(en_b), su_b, hi_b, int'(ca_b), rl_b, bz_b, ov_b));
  endtask

  initial begin
    logic [31:0] w;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, 1};
    tbl[2] = '{5, 0, 1, 0, 0, 0, 1};
    tbl[3] = '{6, 2, 0, 0, 0, 0, 1};
    tbl[4] = '{10, 0, 2, 0, 0, 0, 1};
    tbl[5] = '{11, 3, 0, 0, 0, 0, 1};
    tbl[6] = '{15, 0, 4, 0, 0, 0, 1};
    tbl[7] = '{16, 4, 0, 0, 0, 0, 1};
    tbl[8] = '{20, 0, 8, 0, 0, 0, 1};
    tbl[9] = '{21, 5, 0, 0, 0, 0, 1};
    tbl[10] = '{25, 0, 16, 0, 0, 0, 1};
    tbl[11] = '{26, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{27, 0, 0, 0, 1, 1, 1};
    tbl[13] = '{28, 0, 0, 0, 0, 0, 0};
    qa.push_back('{"reset", 0, pack(0, 0, 0, 0, 0, 0, 0, 0)});
    qb.push_back('{"reset", 0, pack(0, 0, 0, 0, 0, 0, 0, 0)});
    tick();
    @(posedge clk);
    #1 reset = 1'b1;
    // defaults, single pulse: explicit table, unlisted cycles are plain busy
    for (int t = 0; t <= 28; t++) begin
      w = pack(0, 0, 0, 0, 0, 0, t >= 1 && t <= 27, 0);
      for (int i = 0; i < 14; i++)
        if (tbl[i].cyc == t) w = pack(tbl[i].op, tbl[i].en, tbl[i].s, tbl[i].h, 0, tbl[i].r, tbl[i].b, 0);
      qa.push_back('{"tbl", t, w});
    end
    for (int t = 0; t <= 28; t++) begin
      tick();
      da = t == 0;
    end
    // 3 ops, no wait, 2 channels
    for (int t = 0; t <= 12; t++) qb.push_back('{"ch2", t, model(3, 0, 2, t, 0)});
    for (int t = 0; t <= 12; t++) begin
      tick();
      db = t == 0;
    end
    // datolisto held: back-to-back sequences every 28 cycles
    for (int t = 0; t <= 112; t++) qa.push_back('{"held", t, model(5, 4, 1, t % 28, OVR_EN && t >= 2)});
    for (int t = 0; t <= 112; t++) begin
      tick();
      da = t <= 84;
    end
    // reset mid-sequence, then restart
    for (int t = 0; t <= 60; t++)
      qa.push_back('{"rstmid", t, t < 12 ? model(5, 4, 1, t, OVR_EN) : t <= 30 ? pack(0, 0, 0, 0, 0, 0, 0, 0) : model(5, 4, 1, t - 31, 0)});
    for (int t = 0; t <= 60; t++) begin
      if (t == 12) begin
        @(posedge clk);
        #1 reset = 1'b0;
      end
      if (t == 14) begin
        @(posedge clk);
        #1 reset = 1'b1;
      end
      tick();
      da = t == 0 || t == 31;
    end
    // overrun set, clear, and set-over-clear in the same cycle
    for (int t = 0; t <= 76; t++)
      qa.push_back('{"ovr", t, t < 46 ? model(5, 4, 1, t, OVR_EN && t >= 11 && t <= 40) : model(5, 4, 1, t - 46, OVR_EN && t >= 51 && t <= 55)});
    for (int t = 0; t <= 76; t++) begin
      tick();
      da = t == 0 || t == 10 || t == 46 || t == 50;
      clr = t == 40 || t == 50 || t == 55;
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
